uart_piso_tx: RTL and testbench
===============================

// Module: uart_piso_tx
// PURPOSE
//   UART transmit path: parallel-in/serial-out framer. Accepts one WIDTH-bit word per
//   valid/ready handshake and serialises it onto tx as start, data, optional parity and
//   stop bits. Each bit lasts CLKS_PER_BIT clocks, set by an internal baud counter.
//   Sits opposite the team's SIPO receiver and drives the line that receiver samples.
// PARAMETERS
//   WIDTH         8   data bits per frame (>=1)
//   CLKS_PER_BIT  16  clk cycles per serial bit (>=2)
//   PARITY_EN     0   1 = insert parity bit after data
//   PARITY_ODD    0   0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
//   STOP_BITS     1   number of stop bits (1 or 2)
// PORTS
//   clk       in   1      clock; all logic on posedge
//   reset     in   1      synchronous, active-high
//   tx_data   in   WIDTH  word to send; sampled only on accept
//   tx_valid  in   1      word available on tx_data
//   tx_ready  out  1      block can accept a word this cycle
//   tx        out  1      serial line, idle high, registered
//   busy      out  1      frame in progress
// BEHAVIOUR
//   - Reset (sync): tx=1, tx_ready=1, busy=0. FSM -> IDLE. Baud and bit counters -> 0.
//   - Reset mid-frame abandons the frame. tx=1 from the next edge. Word is not resumed.
//   - Accept = tx_valid & tx_ready at posedge. That edge loads tx_data into the shift reg.
//     tx_ready=0 and busy=1 from that edge.
//   - FSM: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
//   - START drives tx=0 from the accept edge, so 1-cycle latency valid->line low.
//   - Each state bit is held exactly CLKS_PER_BIT cycles, timed by the baud counter
//     0..CLKS_PER_BIT-1. Counter restarts at every bit boundary.
//   - DATA sends WIDTH bits, MSB first (shift reg shifts left, tx = sreg[WIDTH-1]).
//     Bit counter runs 0..WIDTH-1 and wraps to 0 on leaving DATA.
//   - PARITY bit = ^data when even. PARITY bit = ~^data when odd.
//   - STOP drives tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
//   - Frame length = (1+WIDTH+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
//   - End of frame: on the edge ending the last stop cycle, FSM -> IDLE, tx_ready=1, busy=0.
//   - Back-to-back: if tx_valid is high in the first IDLE cycle, the next start bit begins
//     on the following edge. Max throughput is 1 frame per frame-length + 1 cycles.
//   - tx_valid while busy is ignored; tx_data is not captured. tx_data changing mid-frame
//     has no effect.
//   - tx is never X after reset. In IDLE, tx=1 always.
// TESTING
//   1 Assert reset 3 cycles with tx_valid=1 -> tx=1, tx_ready=1, busy=0, no frame starts.
//   2 CLKS_PER_BIT=4, send 0xA5 -> tx low 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each,
//     then high 4. tx_ready returns 40 cycles after accept.
//   3 Send 0x00 then 0xFF with tx_valid held high -> second start bit begins exactly 1
//     idle cycle after first stop ends. Both words decode correctly.
//   4 PARITY_EN=1: 0x07 with PARITY_ODD=0 -> parity bit 1. Same word with PARITY_ODD=1 ->
//     parity bit 0. STOP_BITS=2 -> stop high 2*CLKS_PER_BIT cycles.
//   5 Pulse reset during data bit 3 -> tx=1 next cycle, tx_ready=1. New word 0x3C then
//     sends a clean, complete frame.
//   6 Change tx_data and pulse tx_valid while busy -> line still carries the original word.
//     No extra frame follows.

Source files
------------

// File: rtl/uart_piso_tx.sv
// UART transmit framer: takes one parallel word per valid/ready handshake and
// shifts it out MSB first as start, data, optional parity and stop bits.
module uart_piso_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx,
    output logic             busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(WIDTH + 2);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic              PAR_ODD   = (PARITY_ODD != 0);
    localparam logic              HAS_PAR   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic               par_q, par_d;
    logic               tx_q, tx_d;

    logic               baud_last;
    logic [WIDTH-1:0]   sreg_shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sreg_q  <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sreg_q  <= sreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    // tx is registered, so each branch computes the level of the bit that the
    // *next* state will present; this keeps the line glitch-free and 1 cycle behind accept.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        sreg_d     = sreg_q;
        par_d      = par_q;
        tx_d       = tx_q;
        baud_last  = (baud_q == BAUD_LAST);
        sreg_shift = sreg_q << 1;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                bit_d  = '0;
                if (tx_valid) begin
                    sreg_d  = tx_data;
                    par_d   = (^tx_data) ^ PAR_ODD;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end

            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = sreg_q[WIDTH-1];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = HAS_PAR ? PARITY : STOP;
                        tx_d    = HAS_PAR ? par_q : 1'b1;
                    end else begin
                        bit_d  = bit_q + BIT_W'(1);
                        sreg_d = sreg_shift;
                        tx_d   = sreg_shift[WIDTH-1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            STOP: begin
                tx_d = 1'b1;
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                baud_d  = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign tx       = tx_q;

endmodule

// File: tb/tb_uart_piso_tx.sv
// Bench for uart_piso_tx: three differently configured instances, each frame
// compared cycle by cycle against a bit-list reference model of the UART frame.
module tb_uart_piso_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] txData;
    logic [2:0] valid;
    logic [2:0] readyO;
    logic [2:0] txO;
    logic [2:0] busyO;

    int nChecks = 0;
    int nFails  = 0;

    // Per-instance configuration mirrored for the reference model
    int cpb[3]     = '{4, 4, 3};
    int parEn[3]   = '{0, 1, 1};
    int parOdd[3]  = '{0, 0, 1};
    int stopCnt[3] = '{1, 2, 1};

    always #5 clk = ~clk;

    uart_piso_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .tx_data(txData), .tx_valid(valid[0]),
        .tx_ready(readyO[0]), .tx(txO[0]), .busy(busyO[0]));

    uart_piso_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset(reset), .tx_data(txData), .tx_valid(valid[1]),
        .tx_ready(readyO[1]), .tx(txO[1]), .busy(busyO[1]));

    uart_piso_tx #(.WIDTH(8), .CLKS_PER_BIT(3), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .reset(reset), .tx_data(txData), .tx_valid(valid[2]),
        .tx_ready(readyO[2]), .tx(txO[2]), .busy(busyO[2]));

    task automatic check(input string tag, input logic observed, input logic expected);
        nChecks++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%b expected=%b t=%0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int frameLen(input int d);
        return (1 + 8 + parEn[d] + stopCnt[d]) * cpb[d];
    endfunction

    // Line level k cycles after accept, from the frame's bit list
    function automatic logic expLevel(input int d, input logic [7:0] word, input int k);
        int b;
        b = k / cpb[d];
        if (b == 0) return 1'b0;
        if (b <= 8) return word[8 - b];
        if (parEn[d] != 0 && b == 9) return (^word) ^ parOdd[d][0];
        return 1'b1;
    endfunction

    task automatic checkIdle(input int d, input string tag);
        check({tag, "_tx"}, txO[d], 1'b1);
        check({tag, "_ready"}, readyO[d], 1'b1);
        check({tag, "_busy"}, busyO[d], 1'b0);
    endtask

    task automatic idleCycles(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkIdle(d, "idle");
        end
    endtask

    // Called and returns at a negedge. disturbAt/abortAt < 0 disable those actions.
    task automatic applyStimulus(input int d, input logic [7:0] word, input bit keepValid,
                                 input int disturbAt, input int abortAt);
        int len;
        len = frameLen(d);
        txData   = word;
        valid[d] = 1'b1;
        check("ready_before_accept", readyO[d], 1'b1);
        @(negedge clk);
        if (!keepValid) valid[d] = 1'b0;
        for (int k = 0; k < len; k++) begin
            if (k > 0) @(negedge clk);
            check("frame_tx", txO[d], expLevel(d, word, k));
            check("frame_busy", busyO[d], 1'b1);
            check("frame_ready", readyO[d], 1'b0);
            if (disturbAt >= 0 && k == disturbAt) begin
                txData   = ~word;
                valid[d] = 1'b1;
            end else if (disturbAt >= 0 && k == disturbAt + 1) begin
                valid[d] = 1'b0;
            end
            if (k == abortAt) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                checkIdle(d, "abort");
                return;
            end
        end
        @(negedge clk);
        checkIdle(d, "frame_end");
    endtask

    initial begin
        logic [7:0] w;
        reset  = 1'b1;
        valid  = 3'b111;
        txData = 8'h5A;

        // Reset held with valid asserted: every instance stays idle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) checkIdle(d, "reset");
        end
        reset = 1'b0;
        valid = 3'b000;
        @(negedge clk);
        for (int d = 0; d < 3; d++) checkIdle(d, "post_reset");

        applyStimulus(0, 8'hA5, 1'b0, -1, -1);
        idleCycles(0, 2);

        // Back-to-back with valid held: exactly one idle cycle between frames
        applyStimulus(0, 8'h00, 1'b1, -1, -1);
        applyStimulus(0, 8'hFF, 1'b0, -1, -1);
        idleCycles(0, 2);

        applyStimulus(1, 8'h07, 1'b0, -1, -1);
        idleCycles(1, 2);
        applyStimulus(2, 8'h07, 1'b0, -1, -1);
        idleCycles(2, 2);

        // Reset during data bit 3, then a clean frame
        applyStimulus(0, 8'h96, 1'b0, -1, 17);
        idleCycles(0, 8);
        applyStimulus(0, 8'h3C, 1'b0, -1, -1);
        idleCycles(0, 1);

        // New data and a valid pulse mid-frame must be ignored
        applyStimulus(0, 8'h5A, 1'b0, 10, -1);
        idleCycles(0, 12);

        for (int i = 0; i < 3; i++) begin
            for (int d = 0; d < 3; d++) begin
                w = 8'($urandom);
                applyStimulus(d, w, 1'b0, -1, -1);
                idleCycles(d, 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
